mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store unit between the execute stage and the 256x8 data memory
//  (async read, sync write).
//  - Accepts one load/store request per valid/ready handshake.
//  - Drives the memory port for exactly one cycle.
//  - Returns load data, or a store acknowledge, on a valid/ready response channel.
//  - Keeps saturating load and store counters for debug.
// PARAMETERS
//  ADDR_W   8     memory address width
//  DATA_W   8     data width
//  RD_W     3     destination register index width
//  CNT_W    16    width of ld_cnt/st_cnt
//  ADDR_MAX 8'hFF highest legal address (used only with MAU_FAULT_EN)
// PORTS
//  clk         in  1       rising-edge clock
//  rst         in  1       synchronous reset, active-high
//  req_valid   in  1       request present
//  req_ready   out 1       unit can accept a request
//  req_wr      in  1       1=store, 0=load
//  req_addr    in  ADDR_W  byte address
//  req_wdata   in  DATA_W  store data
//  req_rd      in  RD_W    load destination register, passed through
//  resp_valid  out 1       response present
//  resp_ready  in  1       consumer accepts response
//  resp_wr     out 1       response is a store acknowledge
//  resp_rdata  out DATA_W  load data (0 for stores/faults)
//  resp_rd     out RD_W    echoed req_rd
//  resp_fault  out 1       address out of range
//  mem_we      out 1       data memory write enable
//  mem_addr    out ADDR_W  data memory address
//  mem_din     out DATA_W  data memory write data
//  mem_dout    in  DATA_W  data memory read data (combinational)
//  ld_cnt      out CNT_W   completed loads, saturating
//  st_cnt      out CNT_W   completed stores, saturating
// BEHAVIOUR
//  - FSM: IDLE -> ACCESS -> RESP.
//  - Accept: req_valid && req_ready at an edge. Request fields latch into
//    req_q; IDLE->ACCESS.
//  - req_ready = (state==IDLE) || (state==RESP && resp_ready).
//  - Back-to-back: RESP with resp_ready and a new request goes straight to
//    ACCESS. Otherwise RESP && resp_ready -> IDLE, and RESP without
//    resp_ready holds.
//  - ACCESS (exactly 1 cycle):
//    - mem_addr=req_q.addr, mem_din=req_q.wdata.
//    - mem_we = req_q.wr && !fault && !rst, so the write commits at the
//      ACCESS->RESP edge.
//    - Loads capture mem_dout into resp_rdata at that edge. ACCESS->RESP.
//  - Outside ACCESS: mem_we=0, mem_addr and mem_din hold their last values.
//  - Latency: accept at edge N; memory access during cycle N+1; resp_valid
//    from cycle N+2. Peak throughput is 1 request per 2 cycles.
//  - RESP: resp_valid=1; resp_* are stable until resp_valid && resp_ready.
//  - Counters: ld_cnt/st_cnt +1 at the ACCESS->RESP edge (faults not
//    counted). Each saturates at all-ones, no wrap.
//  - Reset (sync, rst priority over all):
//    - state=IDLE; resp_valid=0, resp_wr=0, resp_rdata=0, resp_rd=0,
//      resp_fault=0; mem_addr=0, mem_din=0; ld_cnt=st_cnt=0.
//    - req_ready=1 after the reset edge.
//    - rst high during ACCESS suppresses the store (mem_we gated
//      combinationally) and discards the in-flight request.
//    - Requests presented while rst=1 are not accepted.
//  - Simultaneous resp handshake and new accept in RESP: old response
//    retires, new one enters ACCESS, and resp_valid drops for 1 cycle.
// CONFIGURATION
//  - MAU_FAULT_EN defined:
//    - req_addr > ADDR_MAX sets fault in ACCESS: no memory write,
//      resp_rdata=0, resp_fault=1, counters unchanged.
//    - Timing is identical to a legal access.
//  - MAU_FAULT_EN undefined: resp_fault is tied 0, ADDR_MAX is ignored,
//    and every address accesses memory.
// STRUCTURE
//  - mau_pkg:
//    - state enum {IDLE,ACCESS,RESP} (2-bit)
//    - req struct {wr,addr,wdata,rd}
//    - localparam defaults for ADDR_W, DATA_W, RD_W
//  - Sub-module sat_counter #(W): en, clear-on-rst, holds at max.
//    Instantiated twice, for ld_cnt and st_cnt.
// TESTING
//  1. Reset, then store addr 8'h10 data 8'hA5: mem_we=1 for exactly 1
//     cycle (N+1), addr 10, din A5. resp_valid at N+2 with resp_wr=1;
//     st_cnt=1.
//  2. Load 8'h10 with model memory returning A5, req_rd=3: resp_rdata=A5,
//     resp_rd=3, resp_wr=0 at N+2; ld_cnt=1; mem_we stays 0.
//  3. Hold resp_ready=0 for 5 cycles: resp_* stable, req_ready=0, no
//     second accept. Then resp_ready=1 with a queued request: accepted on
//     the same edge.
//  4. Assert rst during the ACCESS cycle of a store to 8'h20: no write
//     occurs, memory[20] is unchanged, all outputs at reset values next
//     cycle.
//  5. Force ld_cnt to 16'hFFFE via preload, then perform 3 loads:
//     counter ends at FFFF.
//  6. MAU_FAULT_EN, ADDR_MAX=8'h7F, store to 8'h80: mem_we never asserts,
//     resp_fault=1, st_cnt unchanged. Undefined build: the same store is
//     written and resp_fault=0.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and width defaults for the load/store unit.
package mau_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned RD_W_DEF   = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
      logic [RD_W_DEF-1:0]   rd;
   } req_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that clears on reset and holds once it reaches all-ones.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (en && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and a 256x8 async-read/sync-write memory.
// Define MAU_FAULT_EN to report addresses above ADDR_MAX as faults.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEF,
   parameter int unsigned       DATA_W   = DATA_W_DEF,
   parameter int unsigned       RD_W     = RD_W_DEF,
   parameter int unsigned       CNT_W    = 16,
   parameter logic [ADDR_W-1:0] ADDR_MAX = '1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [RD_W-1:0]   req_rd,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_wr,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [RD_W-1:0]   resp_rd,
   output logic              resp_fault,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [CNT_W-1:0]  ld_cnt,
   output logic [CNT_W-1:0]  st_cnt
);

   state_t state;
   req_t   req_q;
   logic   accept;
   logic   fault;
   logic   in_access;

`ifdef MAU_FAULT_EN
   assign fault = (req_q.addr > ADDR_MAX);
`else
   logic unused_addr_max;
   assign unused_addr_max = ^ADDR_MAX;
   assign fault = 1'b0;
`endif

   assign req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
   assign accept    = req_valid && req_ready;
   assign in_access = (state == ACCESS);

   // req_q is only reloaded on accept, so the memory port naturally holds
   // its last address/data outside ACCESS.
   assign mem_addr = req_q.addr;
   assign mem_din  = req_q.wdata;
   assign mem_we   = in_access && req_q.wr && !fault && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_q      <= '0;
         resp_valid <= 1'b0;
         resp_wr    <= 1'b0;
         resp_rdata <= '0;
         resp_rd    <= '0;
         resp_fault <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  req_q <= '{wr: req_wr, addr: req_addr, wdata: req_wdata, rd: req_rd};
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               resp_valid <= 1'b1;
               resp_wr    <= req_q.wr;
               resp_rd    <= req_q.rd;
               resp_fault <= fault;
               resp_rdata <= (req_q.wr || fault) ? '0 : mem_dout;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  if (req_valid) begin
                     req_q <= '{wr: req_wr, addr: req_addr, wdata: req_wdata, rd: req_rd};
                     state <= ACCESS;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_ld_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (in_access && !req_q.wr && !fault),
      .count (ld_cnt)
   );

   sat_counter #(.W(CNT_W)) u_st_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (in_access && req_q.wr && !fault),
      .count (st_cnt)
   );

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a behavioural model.
module tb_mem_access_unit;

   localparam int unsigned CW = 4;
   localparam logic [7:0]  AMAX = 8'h7F;
`ifdef MAU_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic req_valid = 1'b0, req_ready, req_wr = 1'b0;
   logic [7:0] req_addr = '0, req_wdata = '0;
   logic [2:0] req_rd = '0;
   logic resp_valid, resp_ready = 1'b0, resp_wr, resp_fault;
   logic [7:0] resp_rdata;
   logic [2:0] resp_rd;
   logic mem_we;
   logic [7:0] mem_addr, mem_din, mem_dout;
   logic [CW-1:0] ld_cnt, st_cnt;

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   int unsigned we_count = 0;
   int unsigned exp_ld = 0, exp_st = 0;
   int unsigned tests = 0, fails = 0;

   always #5 clk = ~clk;

   assign mem_dout = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_din;
         we_count <= we_count + 1;
      end
   end

   mem_access_unit #(.CNT_W(CW), .ADDR_MAX(AMAX)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wr(resp_wr),
      .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_fault(resp_fault),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .ld_cnt(ld_cnt), .st_cnt(st_cnt)
   );

   function automatic logic [CW-1:0] sat(input int unsigned v);
      return (v >= (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(v);
   endfunction

   function automatic bit is_fault(input logic [7:0] a);
      return FAULT_EN && (a > AMAX);
   endfunction

   // One full transaction from an idle unit; stall = cycles resp_ready stays low.
   task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [2:0] rd, input int unsigned stall);
      bit f;
      logic [7:0] exp_rdata;
      int unsigned we0;
      int unsigned n;
      f = is_fault(addr);
      exp_rdata = (wr || f) ? 8'h00 : ref_mem[addr];
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_rd = rd;
      resp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      tests++; if (!req_ready) begin fails++; $display("FAIL txn_ready_timeout got %b exp 1", req_ready); end
      we0 = we_count;
      @(negedge clk);
      req_valid = 1'b0;
      tests++; if (mem_we !== (wr && !f)) begin fails++; $display("FAIL access_we got %b exp %b", mem_we, wr && !f); end
      tests++; if (mem_addr !== addr) begin fails++; $display("FAIL access_addr got %h exp %h", mem_addr, addr); end
      tests++; if (wr && mem_din !== wdata) begin fails++; $display("FAIL access_din got %h exp %h", mem_din, wdata); end
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL access_rvalid got %b exp 0", resp_valid); end
      resp_ready = (stall == 0);
      @(negedge clk);
      if (wr && !f) ref_mem[addr] = wdata;
      if (!f) begin if (wr) exp_st++; else exp_ld++; end
      tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL resp_valid got %b exp 1", resp_valid); end
      tests++; if (resp_wr !== wr) begin fails++; $display("FAIL resp_wr got %b exp %b", resp_wr, wr); end
      tests++; if (resp_rdata !== exp_rdata) begin fails++; $display("FAIL resp_rdata got %h exp %h", resp_rdata, exp_rdata); end
      tests++; if (resp_rd !== rd) begin fails++; $display("FAIL resp_rd got %h exp %h", resp_rd, rd); end
      tests++; if (resp_fault !== f) begin fails++; $display("FAIL resp_fault got %b exp %b", resp_fault, f); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL resp_we got %b exp 0", mem_we); end
      tests++; if (we_count - we0 !== ((wr && !f) ? 1 : 0)) begin fails++; $display("FAIL we_pulses got %0d exp %0d", we_count - we0, (wr && !f) ? 1 : 0); end
      tests++; if (mem[addr] !== ref_mem[addr]) begin fails++; $display("FAIL mem_content got %h exp %h", mem[addr], ref_mem[addr]); end
      tests++; if (ld_cnt !== sat(exp_ld)) begin fails++; $display("FAIL ld_cnt got %h exp %h", ld_cnt, sat(exp_ld)); end
      tests++; if (st_cnt !== sat(exp_st)) begin fails++; $display("FAIL st_cnt got %h exp %h", st_cnt, sat(exp_st)); end
      for (int unsigned i = 0; i < stall; i++) begin
         @(negedge clk);
         tests++; if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_rd !== rd || resp_wr !== wr)
            begin fails++; $display("FAIL stall_hold got v=%b d=%h exp v=1 d=%h", resp_valid, resp_rdata, exp_rdata); end
         tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL stall_ready got %b exp 0", req_ready); end
      end
      resp_ready = 1'b1;
      @(negedge clk);
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL retire_valid got %b exp 0", resp_valid); end
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h55;
      @(negedge clk); @(negedge clk);
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", mem_we); end
      rst = 1'b0; req_valid = 1'b0;
      exp_ld = 0; exp_st = 0;
      tests++; if (resp_valid !== 1'b0 || resp_wr !== 1'b0 || resp_rdata !== 8'h00 || resp_rd !== 3'd0 || resp_fault !== 1'b0)
         begin fails++; $display("FAIL reset_resp got v=%b w=%b d=%h r=%h f=%b exp zeros", resp_valid, resp_wr, resp_rdata, resp_rd, resp_fault); end
      tests++; if (mem_addr !== 8'h00 || mem_din !== 8'h00) begin fails++; $display("FAIL reset_mem got a=%h d=%h exp 00", mem_addr, mem_din); end
      tests++; if (ld_cnt !== '0 || st_cnt !== '0) begin fails++; $display("FAIL reset_cnt got %h/%h exp 0", ld_cnt, st_cnt); end
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_store_load();
      run_txn(1'b1, 8'h10, 8'hA5, 3'd0, 0);
      run_txn(1'b0, 8'h10, 8'h00, 3'd3, 0);
   endtask

   task automatic test_stall_queued();
      logic [7:0] d;
      d = 8'($urandom);
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h33; req_wdata = d; req_rd = 3'd1;
      @(negedge clk);
      req_wr = 1'b0; req_addr = 8'h10; req_rd = 3'd6;
      @(negedge clk);
      ref_mem[8'h33] = d; exp_st++;
      for (int unsigned i = 0; i < 5; i++) begin
         tests++; if (resp_valid !== 1'b1 || resp_wr !== 1'b1 || resp_rd !== 3'd1)
            begin fails++; $display("FAIL queued_hold got v=%b w=%b r=%h exp 1/1/1", resp_valid, resp_wr, resp_rd); end
         tests++; if (req_ready !== 1'b0 || mem_addr !== 8'h33) begin fails++; $display("FAIL queued_noaccept got rdy=%b a=%h exp 0/33", req_ready, mem_addr); end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      #1;
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL queued_ready got %b exp 1", req_ready); end
      @(negedge clk);
      req_valid = 1'b0;
      tests++; if (resp_valid !== 1'b0 || mem_addr !== 8'h10) begin fails++; $display("FAIL queued_accept got v=%b a=%h exp 0/10", resp_valid, mem_addr); end
      @(negedge clk);
      exp_ld++;
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== ref_mem[8'h10] || resp_rd !== 3'd6)
         begin fails++; $display("FAIL queued_resp got v=%b d=%h r=%h exp 1/%h/6", resp_valid, resp_rdata, resp_rd, ref_mem[8'h10]); end
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_rst_in_access();
      int unsigned we0;
      we0 = we_count;
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h20; req_wdata = ~ref_mem[8'h20]; req_rd = 3'd2;
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b1;
      #1;
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_gate_we got %b exp 0", mem_we); end
      @(negedge clk);
      rst = 1'b0; exp_ld = 0; exp_st = 0;
      tests++; if (we_count !== we0 || mem[8'h20] !== ref_mem[8'h20]) begin fails++; $display("FAIL rst_no_write got %h exp %h", mem[8'h20], ref_mem[8'h20]); end
      tests++; if (resp_valid !== 1'b0 || mem_addr !== 8'h00 || mem_din !== 8'h00 || ld_cnt !== '0 || st_cnt !== '0 || req_ready !== 1'b1)
         begin fails++; $display("FAIL rst_outputs got v=%b a=%h d=%h l=%h s=%h r=%b exp 0/00/00/0/0/1", resp_valid, mem_addr, mem_din, ld_cnt, st_cnt, req_ready); end
   endtask

   task automatic test_saturation();
      for (int unsigned i = 0; i < (1 << CW) + 2; i++)
         run_txn(1'b0, 8'($urandom_range(0, 127)), 8'h00, 3'($urandom), 0);
      tests++; if (ld_cnt !== '1) begin fails++; $display("FAIL ld_saturate got %h exp all-ones", ld_cnt); end
   endtask

   task automatic test_fault();
      run_txn(1'b1, 8'h80, 8'h5A, 3'd4, 0);
      run_txn(1'b0, 8'hC3, 8'h00, 3'd5, 1);
   endtask

   task automatic test_back_to_back();
      logic [7:0] a [8];
      logic [7:0] d [8];
      logic       w [8];
      logic [2:0] r [8];
      for (int unsigned i = 0; i < 8; i++) begin
         a[i] = 8'($urandom); d[i] = 8'($urandom); w[i] = 1'($urandom); r[i] = 3'($urandom);
      end
      resp_ready = 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
         req_valid = 1'b1; req_wr = w[i]; req_addr = a[i]; req_wdata = d[i]; req_rd = r[i];
         @(negedge clk);
         tests++; if (resp_valid !== 1'b0 || mem_addr !== a[i]) begin fails++; $display("FAIL b2b_access got v=%b a=%h exp 0/%h", resp_valid, mem_addr, a[i]); end
         if (i == 7) req_valid = 1'b0;
         @(negedge clk);
         tests++;
         if (resp_valid !== 1'b1 || resp_wr !== w[i] || resp_rd !== r[i] || resp_fault !== is_fault(a[i]) ||
             resp_rdata !== ((w[i] || is_fault(a[i])) ? 8'h00 : ref_mem[a[i]]))
            begin fails++; $display("FAIL b2b_resp got v=%b d=%h exp 1/%h", resp_valid, resp_rdata, (w[i] || is_fault(a[i])) ? 8'h00 : ref_mem[a[i]]); end
         if (!is_fault(a[i])) begin
            if (w[i]) begin ref_mem[a[i]] = d[i]; exp_st++; end else exp_ld++;
         end
      end
      @(negedge clk);
      resp_ready = 1'b0;
      tests++; if (ld_cnt !== sat(exp_ld) || st_cnt !== sat(exp_st)) begin fails++; $display("FAIL b2b_cnt got %h/%h exp %h/%h", ld_cnt, st_cnt, sat(exp_ld), sat(exp_st)); end
   endtask

   task automatic test_random();
      for (int unsigned i = 0; i < 25; i++)
         run_txn(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), $urandom_range(0, 3));
   endtask

   initial begin
      for (int unsigned i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      @(negedge clk);
      test_reset();
      test_store_load();
      test_stall_queued();
      test_rst_in_access();
      test_fault();
      test_back_to_back();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
